// File: rtl/customer_driver.sv
// customer_driver: buys tickets by pulsing coins into a vendor, strobes done, then tallies the vendor's return pulses
module customer_driver #(
  parameter int DW      = 8,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] req_dest,
  input  logic [DW-1:0] req_count,
  input  logic [DW-1:0] req_ones,
  input  logic [DW-1:0] req_tens,
  output logic [DW-1:0] input_dest,
  output logic [DW-1:0] input_count,
  output logic          coin_one_in_pulse,
  output logic          coin_ten_in_pulse,
  output logic          done,
  input  logic          ticket_pulse,
  input  logic          coin_one_out_pulse,
  input  logic          coin_ten_out_pulse,
  output logic          busy,
  output logic          result_valid,
  output logic [DW-1:0] got_tickets,
  output logic [DW-1:0] got_ones,
  output logic [DW-1:0] got_tens
);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [2:0] {IDLE, INS_TEN, INS_ONE, DONE, COLLECT, REPORT} state_t;
  state_t        state;
  logic [DW-1:0] tens_left, ones_left;
  logic [GW-1:0] gap;
  logic [7:0]    quiet;
  logic [2:0]    ret_r, ret_p, ret_e;
  logic          cnt_en;
  assign ret_e  = ret_r & ~ret_p;
  assign cnt_en = state == DONE || state == COLLECT;
  function automatic logic [DW-1:0] sat(input logic [DW-1:0] v, input logic e);
    return (e && v != '1) ? v + 1'b1 : v;
  endfunction
  // Each coin/done decision is made on the edge that drives it, so the cycle after start is a lead-in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      tens_left         <= '0;
      ones_left         <= '0;
      gap               <= '0;
      quiet             <= '0;
      ret_r             <= '0;
      ret_p             <= '0;
      input_dest        <= '0;
      input_count       <= '0;
      coin_one_in_pulse <= 1'b0;
      coin_ten_in_pulse <= 1'b0;
      done              <= 1'b0;
      busy              <= 1'b0;
      result_valid      <= 1'b0;
      got_tickets       <= '0;
      got_ones          <= '0;
      got_tens          <= '0;
    end else begin
      ret_r             <= {ticket_pulse, coin_one_out_pulse, coin_ten_out_pulse};
      ret_p             <= ret_r;
      coin_one_in_pulse <= 1'b0;
      coin_ten_in_pulse <= 1'b0;
      done              <= 1'b0;
      result_valid      <= 1'b0;
      if (cnt_en) begin
        got_tickets <= sat(got_tickets, ret_e[2]);
        got_ones    <= sat(got_ones, ret_e[1]);
        got_tens    <= sat(got_tens, ret_e[0]);
      end
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            input_dest  <= req_dest;
            input_count <= req_count;
            tens_left   <= req_tens;
            ones_left   <= req_ones;
            gap         <= '0;
            state       <= req_tens != '0 ? INS_TEN : INS_ONE;
          end
        end
        INS_TEN, INS_ONE: begin
          busy <= 1'b1;
          if (gap != '0) gap <= gap - 1'b1;
          else if (tens_left != '0) begin
            coin_ten_in_pulse <= 1'b1;
            tens_left         <= tens_left - 1'b1;
            gap               <= GW'(GAP);
            state             <= INS_TEN;
          end else if (ones_left != '0) begin
            coin_one_in_pulse <= 1'b1;
            ones_left         <= ones_left - 1'b1;
            gap               <= GW'(GAP);
            state             <= INS_ONE;
          end else begin
            done        <= 1'b1;
            got_tickets <= '0;
            got_ones    <= '0;
            got_tens    <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          quiet <= '0;
          state <= COLLECT;
        end
        COLLECT: begin
          if (ret_e != '0) quiet <= '0;
          else if (quiet == 8'(TIMEOUT - 1)) begin
            result_valid <= 1'b1;
            state        <= REPORT;
          end else quiet <= quiet + 8'd1;
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_customer_driver.sv
// tb_customer_driver: directed purchases with a cycle-stamped scoreboard of coin, done and result strobes
module tb_customer_driver;
  localparam int T = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] req_dest = '0, req_count = '0, req_ones = '0, req_tens = '0;
  logic [7:0] input_dest, input_count, got_tickets, got_ones, got_tens;
  logic coin_one_in_pulse, coin_ten_in_pulse, done, busy, result_valid;
  logic ticket_pulse = 1'b0, coin_one_out_pulse = 1'b0, coin_ten_out_pulse = 1'b0;
  logic start2 = 1'b0, ticket2 = 1'b0;
  logic [3:0] tens2 = '0, dest2, count2, gt2, go2, gn2;
  logic c1_2, c10_2, done2, busy2, rv2;
  int cyc = 0, n_checks = 0, n_fail = 0;
  typedef struct {int kind; int at; logic [7:0] t, o, n;} ev_t;
  ev_t q[$];
  logic [2:0] ret_tab [12] = '{3'b111, 3'b000, 3'b110, 3'b000, 3'b110, 3'b000,
                               3'b100, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000};

  customer_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_dest(req_dest), .req_count(req_count),
    .req_ones(req_ones), .req_tens(req_tens), .input_dest(input_dest), .input_count(input_count),
    .coin_one_in_pulse(coin_one_in_pulse), .coin_ten_in_pulse(coin_ten_in_pulse), .done(done),
    .ticket_pulse(ticket_pulse), .coin_one_out_pulse(coin_one_out_pulse),
    .coin_ten_out_pulse(coin_ten_out_pulse), .busy(busy), .result_valid(result_valid),
    .got_tickets(got_tickets), .got_ones(got_ones), .got_tens(got_tens)
  );

  customer_driver #(.DW(4), .GAP(2), .TIMEOUT(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .req_dest(4'd3), .req_count(4'd1),
    .req_ones(4'd0), .req_tens(tens2), .input_dest(dest2), .input_count(count2),
    .coin_one_in_pulse(c1_2), .coin_ten_in_pulse(c10_2), .done(done2),
    .ticket_pulse(ticket2), .coin_one_out_pulse(1'b0), .coin_ten_out_pulse(1'b0),
    .busy(busy2), .result_valid(rv2), .got_tickets(gt2), .got_ones(go2), .got_tens(gn2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int kind, int at, logic [7:0] t, logic [7:0] o, logic [7:0] n);
    ev_t e;
    e.kind = kind; e.at = at; e.t = t; e.o = o; e.n = n;
    q.push_back(e);
  endtask

  // kinds: 0 ten coin, 1 one coin, 2 done, 3 result; GAP=1 gives one pulse every 2 cycles
  task automatic plan(int k, int tens, int ones, output int d);
    for (int i = 0; i < tens; i++) push(0, k + 1 + 2 * i, 0, 0, 0);
    for (int i = 0; i < ones; i++) push(1, k + 1 + 2 * tens + 2 * i, 0, 0, 0);
    d = k + 1 + 2 * (tens + ones);
    push(2, d, 0, 0, 0);
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic go(logic [7:0] dest, logic [7:0] cnt, logic [7:0] ones, logic [7:0] tens,
                    bit rel, output int k);
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    req_dest = dest; req_count = cnt; req_ones = ones; req_tens = tens; start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic monitor();
    logic [3:0] s;
    ev_t e;
    forever begin
      @(negedge clk);
      s = {result_valid, done, coin_one_in_pulse, coin_ten_in_pulse};
      for (int b = 0; b < 4; b++) if (s[b]) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: kind %0d at cycle %0d, required none", b, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind != b || e.at != cyc ||
              (b >= 2 && {got_tickets, got_ones, got_tens} != {e.t, e.o, e.n})) begin
            n_fail++;
            $display("FAIL strobe: actual kind %0d cycle %0d got %0d/%0d/%0d, required kind %0d cycle %0d got %0d/%0d/%0d",
                     b, cyc, got_tickets, got_ones, got_tens, e.kind, e.at, e.t, e.o, e.n);
          end
        end
      end
    end
  endtask

  initial begin
    int k, d, r, dc;
    bit seen;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_input_dest", input_dest, 0);
    chk("rst_input_count", input_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {done, result_valid, coin_one_in_pulse, coin_ten_in_pulse}, 0);
    chk("rst_got", {got_tickets, got_ones, got_tens}, 0);
    // full purchase with returns, start on the first edge after reset release
    go(8'h5A, 8'd3, 8'd3, 8'd2, 1'b1, k);
    plan(k, 2, 3, d);
    chk("busy_start_cycle", busy, 0);
    wait_to(k + 1);
    chk("busy_after_start", busy, 1);
    chk("input_dest", input_dest, 8'h5A);
    chk("input_count", input_count, 3);
    r = d + 13 + T;
    push(3, r, 4, 5, 1);
    for (int i = 0; i < 12; i++) begin
      wait_to(d + 1 + i);
      {ticket_pulse, coin_one_out_pulse, coin_ten_out_pulse} = ret_tab[i];
    end
    wait_to(r);
    chk("busy_report", busy, 1);
    wait_to(r + 1);
    chk("busy_after_report", busy, 0);
    wait_to(r + 3);
    chk("got_hold", {got_tickets, got_ones, got_tens}, {8'd4, 8'd5, 8'd1});
    // reset during INS_ONE
    go(8'h44, 8'd7, 8'd3, 8'd0, 1'b0, k);
    push(1, k + 1, 0, 0, 0);
    wait_to(k + 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_coin", coin_one_in_pulse, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_dest", input_dest, 0);
    chk("async_rst_got", got_tickets, 0);
    repeat (2) @(negedge clk);
    go(8'h45, 8'd1, 8'd1, 8'd1, 1'b1, k);
    plan(k, 1, 1, d);
    push(3, d + 1 + T, 0, 0, 0);
    wait_to(d + 2 + T);
    chk("dest_after_reset", input_dest, 8'h45);
    // no coins
    go(8'h01, 8'd1, 8'd0, 8'd0, 1'b0, k);
    push(2, k + 1, 0, 0, 0);
    push(3, k + 2 + T, 0, 0, 0);
    wait_to(k + 3 + T);
    // start while busy is ignored
    go(8'h33, 8'd2, 8'd1, 8'd1, 1'b0, k);
    plan(k, 1, 1, d);
    push(3, d + 1 + T, 0, 0, 0);
    wait_to(k + 2);
    req_dest = 8'hEE; req_tens = 8'd5; req_count = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dest_busy_start", input_dest, 8'h33);
    wait_to(d + 2 + T);
    chk("dest_after_ignored", input_dest, 8'h33);
    chk("count_after_ignored", input_count, 2);
    // long ticket pulse counts once
    go(8'h02, 8'd1, 8'd0, 8'd0, 1'b0, k);
    d = k + 1;
    push(2, d, 0, 0, 0);
    push(3, d + 2 + T, 1, 0, 0);
    wait_to(d);
    ticket_pulse = 1'b1;
    wait_to(d + 5);
    ticket_pulse = 1'b0;
    wait_to(d + 3 + T);
    // DW=4, GAP=2: done after one ten coin plus two gap cycles, tickets saturate at 15
    @(negedge clk);
    tens2 = 4'd1; start2 = 1'b1; k = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    dc = -1;
    for (int i = 0; i < 20 && dc < 0; i++) begin
      @(negedge clk);
      if (done2) dc = cyc;
    end
    chk("dut2_done_cycle", dc, k + 4);
    for (int i = 0; i < 20; i++) begin
      ticket2 = 1'b1; @(negedge clk);
      ticket2 = 1'b0; @(negedge clk);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rv2) seen = 1'b1;
      else @(negedge clk);
    end
    chk("dut2_result_seen", seen, 1);
    chk("dut2_sat_tickets", gt2, 15);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
